uart_lite_ctrl: RTL and testbench
=================================

Name: uart_lite_ctrl

Overview:
AXI4-Lite master that owns an AXI UART Lite core and hides its register map behind two byte streams. After reset it writes the core's control register. It then polls the status register and arbitrates round-robin between two services: pushing TX stream bytes into the core's TX FIFO, and draining the RX FIFO into the RX stream. It sits between the application logic and the UART Lite slave port; it is the only master on that port.

Parameters:
POLL_GAP, 8, idle cycles between status polls when the previous poll found no work (0 = back-to-back polls)
CTRL_INIT, 32'h13, value written to CTRL (0xC) at init: reset TX and RX FIFOs, enable interrupt

Ports:
s_axi_aclk  in  1  clock
s_axi_areset  in  1  asynchronous active-high reset
m_axi_awaddr  out  4  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  write strobes; always 4'b0001 when wvalid
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  4  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  one-cycle pulse: byte accepted (write response received)
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid; held until rx_ready
rx_ready  in  1  consumer accepts rx_data
err_overrun  out  1  sticky: STAT bit5 seen set
err_frame  out  1  sticky: STAT bit6 seen set
err_parity  out  1  sticky: STAT bit7 seen set
bus_err  out  1  sticky: any bresp or rresp != 2'b00
err_clr  in  1  synchronous clear of all sticky error flags
init_done  out  1  high once the CTRL write has completed

Behaviour:
- Reset values: all valid/ready outputs 0; addresses, wdata and wstrb 0; rx_data 0; all error flags 0; init_done 0; FSM in INIT_W; round-robin priority = TX.
- Register map: RX FIFO 0x0, TX FIFO 0x4, STAT 0x8, CTRL 0xC.
- STAT bits used: 0 = RX valid, 3 = TX full, 5 = overrun, 6 = frame error, 7 = parity error.
- Write transaction:
  - awvalid and wvalid rise in the same cycle.
  - Each one drops the cycle after its own ready is sampled high; awready and wready may arrive in either order or together.
  - Enter the B state only once both handshakes are done. bready is 1 only in B states. The transaction completes on bvalid.
- Read transaction:
  - arvalid is held until arready.
  - rready is 1 in R states. rdata and rresp are captured on rvalid.
- FSM states: INIT_W, INIT_B, GAP, STAT_AR, STAT_R, TX_W, TX_B, RX_AR, RX_R.
  - INIT_W: write CTRL_INIT to 0xC. On completion go to INIT_B.
  - INIT_B: on bvalid, set init_done and go to STAT_AR.
  - STAT_AR / STAT_R: read 0x8. On capture, OR bits 5/6/7 into the sticky flags, then decide:
    - tx_ok = tx_valid && !STAT[3].
    - rx_ok = STAT[0] && !rx_valid.
    - Both true: serve per the round-robin priority, then flip the priority.
    - One true: serve that one; the priority is set to the other service.
    - Neither: go to GAP.
  - TX_W / TX_B: write {24'h0, tx_data} to 0x4. tx_data is sampled when TX_W is entered. Pulse tx_ready for 1 cycle on bvalid, then go to STAT_AR.
  - RX_AR / RX_R: read 0x0. On rvalid, load rx_data = rdata[7:0], set rx_valid, go to STAT_AR.
  - GAP: count POLL_GAP cycles, then go to STAT_AR. POLL_GAP = 0 goes to STAT_AR on the next cycle.
- rx_valid clears on the cycle rx_valid && rx_ready. No new RX read is issued while rx_valid = 1, so no byte is ever lost in the controller.
- tx_valid dropping while in TX_W/TX_B does not abort the write; the byte already latched is still sent.
- A response with error (bresp/rresp != 0) sets bus_err; the FSM proceeds as if OKAY. A failed RX read still presents its byte.
- err_clr and a new error in the same cycle: the flag ends set.
- Reset mid-transaction: all valids drop immediately and the FSM returns to INIT_W. The slave is reset by the same system reset.
- interrupt from the core is not used; polling only.

Decomposition:
- Shared package uart_lite_pkg:
  - register offsets ADDR_RX, ADDR_TX, ADDR_STAT, ADDR_CTRL;
  - STAT bit index constants;
  - CTRL bit constants;
  - FSM state enum.
- Sub-module axil_master_single: single-outstanding AXI4-Lite master.
  - Request side: req, we, addr, wdata; response side: done, rdata, resp.
  - Contains the independent AW/W drop logic.
  - The top FSM only sequences requests.

Test Plan:
- Bench setup: a behavioural UART Lite register model with randomised ready/valid delays.
- Reset release: exactly one write of 0x13 to 0xC, wstrb 4'b0001. init_done rises the cycle after bvalid. No other traffic occurs before that.
- TX stream 0xAA, 0x55 with STAT = 0x04: writes 0x000000AA then 0x00000055 to 0x4, in order. Exactly two tx_ready pulses.
- STAT TX full (0x08) with tx_valid held: only STAT reads occur, spaced POLL_GAP+1 apart. Clearing bit3 produces the TX write on the next poll.
- STAT = 0x01, RX FIFO returns 0x3C, rx_ready held low: rx_data = 0x3C and rx_valid held; no second read of 0x0. After rx_ready, the next poll reads 0x0 again.
- TX pending and STAT = 0x01 continuously: service order alternates TX, RX, TX, RX.
- Error cases:
  - STAT = 0x20 sets err_overrun.
  - bresp = 2'b10 on a TX write sets bus_err and the stream continues.
  - err_clr clears both flags.
  - Reset asserted while awvalid = 1: awvalid = 0 in the same cycle, and a fresh CTRL write occurs after release.

Source files
------------

// File: rtl/uart_lite_pkg.sv
// Shared constants and types for the UART Lite polling controller.
package uart_lite_pkg;

    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [3:0] ADDR_CTRL = 4'hC;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;
    localparam int STAT_OVERRUN  = 5;
    localparam int STAT_FRAME    = 6;
    localparam int STAT_PARITY   = 7;

    localparam int CTRL_RST_TX   = 0;
    localparam int CTRL_RST_RX   = 1;
    localparam int CTRL_INTR_EN  = 4;

    typedef enum logic [3:0] {
        INIT_W, INIT_B, GAP, STAT_AR, STAT_R, TX_W, TX_B, RX_AR, RX_R
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE, PH_ADDR, PH_RESP
    } axil_phase_t;

endpackage

// File: rtl/uart_lite_ctrl_if.sv
// AXI4-Lite bus between the controller (master) and the UART Lite core (slave).
interface uart_lite_ctrl_if;
    logic [3:0]  m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [3:0]  m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface

// File: rtl/uart_lite_ctrl_axil_master_single.sv
// Single-outstanding AXI4-Lite master: one read or write per request.
// Response data/resp are passed through and valid only while done is high.
module axil_master_single
    import uart_lite_pkg::*;
(
    input  logic             s_axi_aclk,
    input  logic             s_axi_areset,
    input  logic             req,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic             addr_done,
    output logic             done,
    output logic [31:0]      rdata,
    output logic [1:0]       resp,
    uart_lite_ctrl_if.master axi
);
    axil_phase_t phase;
    logic        we_q;
    logic        aw_fin, w_fin;

    // AW and W complete independently; the address phase ends when both have.
    assign aw_fin    = !axi.m_axi_awvalid || axi.m_axi_awready;
    assign w_fin     = !axi.m_axi_wvalid  || axi.m_axi_wready;
    assign addr_done = (phase == PH_ADDR) &&
                       (we_q ? (aw_fin && w_fin) : (axi.m_axi_arvalid && axi.m_axi_arready));
    assign done      = (phase == PH_RESP) && (we_q ? axi.m_axi_bvalid : axi.m_axi_rvalid);
    assign rdata     = axi.m_axi_rdata;
    assign resp      = we_q ? axi.m_axi_bresp : axi.m_axi_rresp;

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            phase             <= PH_IDLE;
            we_q              <= 1'b0;
            axi.m_axi_awaddr  <= '0;
            axi.m_axi_awvalid <= 1'b0;
            axi.m_axi_wdata   <= '0;
            axi.m_axi_wstrb   <= '0;
            axi.m_axi_wvalid  <= 1'b0;
            axi.m_axi_bready  <= 1'b0;
            axi.m_axi_araddr  <= '0;
            axi.m_axi_arvalid <= 1'b0;
            axi.m_axi_rready  <= 1'b0;
        end else begin
            case (phase)
                PH_IDLE: if (req) begin
                    phase <= PH_ADDR;
                    we_q  <= we;
                    if (we) begin
                        axi.m_axi_awaddr  <= addr;
                        axi.m_axi_wdata   <= wdata;
                        axi.m_axi_wstrb   <= 4'b0001;
                        axi.m_axi_awvalid <= 1'b1;
                        axi.m_axi_wvalid  <= 1'b1;
                    end else begin
                        axi.m_axi_araddr  <= addr;
                        axi.m_axi_arvalid <= 1'b1;
                    end
                end
                PH_ADDR: begin
                    if (axi.m_axi_awready) axi.m_axi_awvalid <= 1'b0;
                    if (axi.m_axi_wready)  axi.m_axi_wvalid  <= 1'b0;
                    if (axi.m_axi_arready) axi.m_axi_arvalid <= 1'b0;
                    if (addr_done) begin
                        phase <= PH_RESP;
                        if (we_q) axi.m_axi_bready <= 1'b1;
                        else      axi.m_axi_rready <= 1'b1;
                    end
                end
                PH_RESP: if (done) begin
                    phase            <= PH_IDLE;
                    axi.m_axi_bready <= 1'b0;
                    axi.m_axi_rready <= 1'b0;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_lite_ctrl.sv
// Polling controller for an AXI UART Lite core: initialises CTRL, then
// round-robins between feeding the TX FIFO and draining the RX FIFO.
module uart_lite_ctrl
    import uart_lite_pkg::*;
#(
    parameter int unsigned POLL_GAP  = 8,
    parameter logic [31:0] CTRL_INIT = 32'h13
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_areset,
    uart_lite_ctrl_if.master m_axi,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             err_overrun,
    output logic             err_frame,
    output logic             err_parity,
    output logic             bus_err,
    input  logic             err_clr,
    output logic             init_done
);
    localparam int          GAP_W      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned GAP_LAST_I = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_LAST_I[GAP_W-1:0];

    state_t            state, state_nxt;
    logic              prio_tx, prio_tx_nxt;
    logic [7:0]        tx_byte;
    logic [GAP_W-1:0]  gap_cnt;

    logic              req, we;
    logic [3:0]        addr;
    logic [31:0]       wdata;
    logic              addr_done, done;
    logic [31:0]       rdata;
    logic [1:0]        resp;
    logic              tx_ok, rx_ok, stat_hit;

    axil_master_single u_axil (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_areset (s_axi_areset),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .addr_done    (addr_done),
        .done         (done),
        .rdata        (rdata),
        .resp         (resp),
        .axi          (m_axi)
    );

    assign tx_ok    = tx_valid && !rdata[STAT_TX_FULL];
    assign rx_ok    = rdata[STAT_RX_VALID] && !rx_valid;
    assign stat_hit = (state == STAT_R) && done;

    always_comb begin
        state_nxt   = state;
        prio_tx_nxt = prio_tx;
        req         = 1'b0;
        we          = 1'b0;
        addr        = ADDR_STAT;
        wdata       = '0;
        case (state)
            INIT_W: begin
                req = 1'b1; we = 1'b1; addr = ADDR_CTRL; wdata = CTRL_INIT;
                if (addr_done) state_nxt = INIT_B;
            end
            INIT_B:  if (done) state_nxt = STAT_AR;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = STAT_AR;
            STAT_AR: begin
                req = 1'b1; addr = ADDR_STAT;
                if (addr_done) state_nxt = STAT_R;
            end
            STAT_R: if (done) begin
                // Whichever service runs, priority goes to the other one.
                if (tx_ok && (prio_tx || !rx_ok)) begin
                    state_nxt = TX_W;  prio_tx_nxt = 1'b0;
                end else if (rx_ok) begin
                    state_nxt = RX_AR; prio_tx_nxt = 1'b1;
                end else begin
                    state_nxt = GAP;
                end
            end
            TX_W: begin
                req = 1'b1; we = 1'b1; addr = ADDR_TX; wdata = {24'h0, tx_byte};
                if (addr_done) state_nxt = TX_B;
            end
            TX_B:  if (done) state_nxt = STAT_AR;
            RX_AR: begin
                req = 1'b1; addr = ADDR_RX;
                if (addr_done) state_nxt = RX_R;
            end
            RX_R:  if (done) state_nxt = STAT_AR;
            default: state_nxt = INIT_W;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state       <= INIT_W;
            prio_tx     <= 1'b1;
            tx_byte     <= '0;
            gap_cnt     <= '0;
            tx_ready    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_overrun <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            bus_err     <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            prio_tx  <= prio_tx_nxt;
            tx_ready <= (state == TX_B) && done;
            gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            // Byte is frozen on entry so a late tx_valid drop cannot alter it.
            if (state_nxt == TX_W && state != TX_W) tx_byte <= tx_data;
            if (state == INIT_B && done) init_done <= 1'b1;
            if (state == RX_R && done) begin
                rx_data  <= rdata[7:0];
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // A new error in the clearing cycle wins over err_clr.
            err_overrun <= (err_overrun && !err_clr) || (stat_hit && rdata[STAT_OVERRUN]);
            err_frame   <= (err_frame   && !err_clr) || (stat_hit && rdata[STAT_FRAME]);
            err_parity  <= (err_parity  && !err_clr) || (stat_hit && rdata[STAT_PARITY]);
            bus_err     <= (bus_err     && !err_clr) || (done && resp != 2'b00);
        end
    end
endmodule

// File: tb/tb_uart_lite_ctrl.sv
// Directed bench for uart_lite_ctrl against a behavioural UART Lite register slave.
module tb_uart_lite_ctrl;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       err_overrun, err_frame, err_parity, bus_err;
    logic       err_clr = 1'b0;
    logic       init_done;

    always #5 clk = ~clk;

    uart_lite_ctrl_if bus();

    uart_lite_ctrl #(.POLL_GAP(GAP), .CTRL_INIT(32'h13)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .m_axi        (bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .err_overrun  (err_overrun),
        .err_frame    (err_frame),
        .err_parity   (err_parity),
        .bus_err      (bus_err),
        .err_clr      (err_clr),
        .init_done    (init_done)
    );

    // Slave model state and transaction logs
    logic [7:0]  stat_reg = 8'h00;
    logic [7:0]  rx_byte = 8'h00;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        hold_aw = 1'b0;
    logic        aw_got, w_got, ar_got;
    logic [3:0]  aw_addr_q, ar_addr_q, w_strb_q;
    logic [31:0] w_data_q;
    logic [3:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_strb_q[$];
    logic [3:0]  rd_addr_q[$];
    bit          svc_q[$];
    int          ar_rise_q[$];
    int          cyc = 0;
    int          txr_cnt = 0;
    int          b_init_cyc = 0;
    logic        ar_prev = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_axi_awready <= 1'b0;
            bus.m_axi_wready  <= 1'b0;
            bus.m_axi_bvalid  <= 1'b0;
            bus.m_axi_bresp   <= 2'b00;
            bus.m_axi_arready <= 1'b0;
            bus.m_axi_rvalid  <= 1'b0;
            bus.m_axi_rdata   <= '0;
            bus.m_axi_rresp   <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_addr_q <= '0; ar_addr_q <= '0; w_strb_q <= '0; w_data_q <= '0;
        end else begin
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                aw_got <= 1'b1; aw_addr_q <= bus.m_axi_awaddr; bus.m_axi_awready <= 1'b0;
            end else begin
                bus.m_axi_awready <= !aw_got && !hold_aw && ($urandom_range(0, 2) == 0);
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                w_got <= 1'b1; w_data_q <= bus.m_axi_wdata; w_strb_q <= bus.m_axi_wstrb;
                bus.m_axi_wready <= 1'b0;
            end else begin
                bus.m_axi_wready <= !w_got && ($urandom_range(0, 2) == 0);
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) begin
                bus.m_axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                wr_addr_q.push_back(aw_addr_q);
                wr_data_q.push_back(w_data_q);
                wr_strb_q.push_back(w_strb_q);
                if (aw_addr_q == 4'h4) svc_q.push_back(1'b1);
                if (aw_addr_q == 4'hC) b_init_cyc <= cyc;
            end else if (aw_got && w_got && !bus.m_axi_bvalid && ($urandom_range(0, 1) == 0)) begin
                bus.m_axi_bvalid <= 1'b1; bus.m_axi_bresp <= bresp_cfg;
            end
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                ar_got <= 1'b1; ar_addr_q <= bus.m_axi_araddr; bus.m_axi_arready <= 1'b0;
                rd_addr_q.push_back(bus.m_axi_araddr);
            end else begin
                bus.m_axi_arready <= !ar_got && ($urandom_range(0, 2) == 0);
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                bus.m_axi_rvalid <= 1'b0; ar_got <= 1'b0;
                if (ar_addr_q == 4'h0) svc_q.push_back(1'b0);
            end else if (ar_got && !bus.m_axi_rvalid && ($urandom_range(0, 1) == 0)) begin
                bus.m_axi_rvalid <= 1'b1;
                bus.m_axi_rresp  <= 2'b00;
                bus.m_axi_rdata  <= (ar_addr_q == 4'h8) ? {24'h0, stat_reg} :
                                    (ar_addr_q == 4'h0) ? {24'h0, rx_byte} : 32'h0;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_ready) txr_cnt <= txr_cnt + 1;
        if (bus.m_axi_arvalid && !ar_prev) ar_rise_q.push_back(cyc);
        ar_prev <= bus.m_axi_arvalid;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int wb, rb, sb, ab, tb0, init_cyc, mingap, cnt;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awvalid", bus.m_axi_awvalid, 0);
        chk("rst_wvalid", bus.m_axi_wvalid, 0);
        chk("rst_arvalid", bus.m_axi_arvalid, 0);
        chk("rst_bready_rready", {bus.m_axi_bready, bus.m_axi_rready}, 0);
        chk("rst_addr_strb", {bus.m_axi_awaddr, bus.m_axi_araddr, bus.m_axi_wstrb}, 0);
        chk("rst_wdata", bus.m_axi_wdata, 0);
        chk("rst_stream", {tx_ready, rx_valid, rx_data}, 0);
        chk("rst_flags", {init_done, err_overrun, err_frame, err_parity, bus_err}, 0);

        // Init write
        rst = 1'b0;
        ok = 0; init_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_done) begin ok = 1; init_cyc = cyc; break; end
        end
        chk("init_wait", ok, 1);
        chk("init_wr_count", wr_addr_q.size(), 1);
        chk("init_wr_addr", wr_addr_q[0], 32'hC);
        chk("init_wr_data", wr_data_q[0], 32'h13);
        chk("init_wstrb", wr_strb_q[0], 32'h1);
        chk("init_no_reads", rd_addr_q.size() + int'(bus.m_axi_arvalid), 0);
        chk("init_done_latency", init_cyc, b_init_cyc + 1);

        // TX stream AA, 55
        stat_reg = 8'h04;
        wb = wr_addr_q.size(); tb0 = txr_cnt;
        tx_data = 8'hAA; tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1; break; end
        end
        chk("tx1_wait", ok, 1);
        tx_data = 8'h55;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1; break; end
        end
        chk("tx2_wait", ok, 1);
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("tx_wr_count", wr_addr_q.size() - wb, 2);
        chk("tx_wr0_addr", wr_addr_q[wb], 32'h4);
        chk("tx_wr0_data", wr_data_q[wb], 32'hAA);
        chk("tx_wr1_addr", wr_addr_q[wb+1], 32'h4);
        chk("tx_wr1_data", wr_data_q[wb+1], 32'h55);
        chk("tx_ready_pulses", txr_cnt - tb0, 2);

        // TX FIFO full: only status polls, spaced by the gap
        stat_reg = 8'h08;
        repeat (20) @(negedge clk);
        wb = wr_addr_q.size(); rb = rd_addr_q.size(); ab = ar_rise_q.size();
        tx_data = 8'h77; tx_valid = 1'b1;
        repeat (80) @(negedge clk);
        chk("full_no_write", wr_addr_q.size() - wb, 0);
        cnt = 0;
        for (int i = rb; i < rd_addr_q.size(); i++) if (rd_addr_q[i] != 4'h8) cnt++;
        chk("full_only_stat", cnt, 0);
        chk("full_polls_seen", (ar_rise_q.size() - ab) >= 3, 1);
        mingap = 1000;
        for (int i = ab + 1; i < ar_rise_q.size(); i++)
            if (ar_rise_q[i] - ar_rise_q[i-1] < mingap) mingap = ar_rise_q[i] - ar_rise_q[i-1];
        chk("full_poll_spacing", mingap >= GAP + 1, 1);
        stat_reg = 8'h04;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1; break; end
        end
        chk("full_release_wait", ok, 1);
        tx_valid = 1'b0;
        chk("full_release_data", wr_data_q[wr_data_q.size()-1], 32'h77);

        // RX with consumer stalled
        repeat (20) @(negedge clk);
        rb = rd_addr_q.size();
        rx_byte = 8'h3C; rx_ready = 1'b0; stat_reg = 8'h01;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_valid) begin ok = 1; break; end
        end
        chk("rx_wait", ok, 1);
        chk("rx_data", rx_data, 32'h3C);
        repeat (60) @(negedge clk);
        chk("rx_held", rx_valid, 1);
        cnt = 0;
        for (int i = rb; i < rd_addr_q.size(); i++) if (rd_addr_q[i] == 4'h0) cnt++;
        chk("rx_single_read", cnt, 1);
        rx_byte = 8'h4D; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_valid) begin ok = 1; break; end
        end
        chk("rx2_wait", ok, 1);
        chk("rx2_data", rx_data, 32'h4D);
        cnt = 0;
        for (int i = rb; i < rd_addr_q.size(); i++) if (rd_addr_q[i] == 4'h0) cnt++;
        chk("rx2_read_count", cnt, 2);
        stat_reg = 8'h00; rx_ready = 1'b1;
        repeat (30) @(negedge clk);

        // Both services pending: strict alternation
        sb = svc_q.size();
        tx_data = 8'h11; tx_valid = 1'b1; stat_reg = 8'h01;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (svc_q.size() >= sb + 4) begin ok = 1; break; end
        end
        chk("alt_wait", ok, 1);
        tx_valid = 1'b0; stat_reg = 8'h00;
        chk("alt_0_tx", svc_q[sb], 1);
        chk("alt_1_rx", svc_q[sb+1], 0);
        chk("alt_2_tx", svc_q[sb+2], 1);
        chk("alt_3_rx", svc_q[sb+3], 0);
        repeat (30) @(negedge clk);

        // Sticky errors
        stat_reg = 8'h20;
        repeat (40) @(negedge clk);
        chk("overrun_set", {err_overrun, err_frame, err_parity}, 32'h4);
        stat_reg = 8'h04; bresp_cfg = 2'b10; tx_data = 8'h99; tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1; break; end
        end
        chk("slverr_wait", ok, 1);
        bresp_cfg = 2'b00; tx_data = 8'h5A;
        chk("bus_err_set", bus_err, 1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1; break; end
        end
        chk("after_err_wait", ok, 1);
        tx_valid = 1'b0;
        chk("stream_continues", wr_data_q[wr_data_q.size()-1], 32'h5A);
        repeat (10) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", {err_overrun, bus_err}, 0);

        // Reset in the middle of a write
        hold_aw = 1'b1; tx_data = 8'h42; tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.m_axi_awvalid) begin ok = 1; break; end
        end
        chk("mid_awvalid_wait", ok, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_awvalid", bus.m_axi_awvalid, 0);
        chk("mid_rst_init_done", init_done, 0);
        tx_valid = 1'b0; hold_aw = 1'b0;
        wb = wr_addr_q.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_done) begin ok = 1; break; end
        end
        chk("mid_reinit_wait", ok, 1);
        chk("mid_reinit_addr", wr_addr_q[wb], 32'hC);
        chk("mid_reinit_data", wr_data_q[wb], 32'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
